muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_if.sv | 27 ++
 rtl/muldiv_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// Request/result bundle for the sequential multiply/divide unit.
// Handshake: start is sampled only while busy is low; done (with hi_en/lo_en) pulses for one cycle when hi/lo are final.
interface muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             hi_en;
   logic             lo_en;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, hi_en, lo_en, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi_en, lo_en, hi, lo, div_by_zero
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULTU/MULT/DIVU/DIV: one shift-add or restoring step per cycle, with sign handling
// done on magnitudes in PREP and FIX.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_seq_if.slave  bus,
   output logic [2:0]   dbg_state
);
   typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;
   localparam int CW = $clog2(WIDTH + 1);

   state_t               state_q, state_d;
   logic [1:0]           op_q, op_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, m_q, m_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 neg_q, neg_d, rneg_q, rneg_d, dbz_q, dbz_d;
   logic                 busy_q, busy_d, done_q, done_d, dbzo_q, dbzo_d;

   logic [WIDTH-1:0]     a_abs, b_abs, quo_fix, rem_fix;
   logic [WIDTH:0]       mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0]   prod_fix;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      m_d      = m_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dbz_d    = dbz_q;
      done_d   = 1'b0;
      dbzo_d   = 1'b0;

      a_abs    = (op_q[0] && a_q[WIDTH-1]) ? -a_q : a_q;
      b_abs    = (op_q[0] && b_q[WIDTH-1]) ? -b_q : b_q;
      // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff = div_shift - {1'b0, m_q};
      prod_fix = neg_q ? -acc_q : acc_q;
      quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_d    = bus.op;
               a_d     = bus.a;
               b_d     = bus.b;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            neg_d  = op_q[0] & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            rneg_d = op_q[0] & a_q[WIDTH-1];
            dbz_d  = op_q[1] && (b_q == '0);
            cnt_d  = '0;
            if (op_q[1]) begin
               acc_d = {{WIDTH{1'b0}}, a_abs};
               m_d   = b_abs;
            end else begin
               acc_d = {{WIDTH{1'b0}}, b_abs};
               m_d   = a_abs;
            end
            state_d = (op_q[1] && (b_q == '0)) ? S_FIX : S_RUN;
         end
         S_RUN: begin
            if (op_q[1]) begin
               acc_d = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_DONE;
            done_d  = 1'b1;
            if (dbz_q) begin
               hi_d   = a_q;
               lo_d   = '1;
               dbzo_d = 1'b1;
            end else if (op_q[1]) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbzo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         m_q     <= m_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbzo_q  <= dbzo_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.hi_en       = done_q;
   assign bus.lo_en       = done_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.div_by_zero = dbzo_q;
   assign dbg_state       = state_q;
endmodule
